// File: rtl/uart_autobaud_ctrl_if.sv
// Receiver-side link of the autobaud controller: baud code and hold go out,
// byte-complete pulse and received byte come back.
interface uart_autobaud_ctrl_if;
  logic       rx_done;
  logic [7:0] data_byte;
  logic [2:0] baud_set;
  logic       rx_hold;

  modport master (output baud_set, rx_hold, input rx_done, data_byte);
  modport slave  (input baud_set, rx_hold, output rx_done, data_byte);
endinterface

// File: rtl/uart_autobaud_ctrl.sv
// Autobaud controller: measures the start bit of a 0x55 sync frame, picks one of
// five baud codes, then confirms it by checking the next frame through the receiver.
module uart_autobaud_ctrl #(
  parameter logic [7:0]  SYNC_BYTE      = 8'h55,
  parameter int unsigned MAX_RETRY      = 3,
  parameter logic [23:0] VERIFY_TIMEOUT = 24'd10_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  uart_rx,
  uart_autobaud_ctrl_if.master  rcv,
  output logic                  busy,
  output logic                  locked,
  output logic                  fail,
  output logic [2:0]            retry_cnt,
  output logic [15:0]           meas_width
);

  typedef enum logic [2:0] {
    IDLE, ARM, MEASURE, SETTLE, VERIFY, LOCKED, FAIL
  } state_t;

  localparam logic [15:0] GLITCH_W = 16'd217;
  localparam logic [15:0] BREAK_W  = 16'd7812;

  state_t      state, state_n;
  logic        sync1, line_s, line_prev, fall;
  logic [15:0] cnt, cnt_n, cnt_inc;
  logic [23:0] tcnt, tcnt_n;
  logic [2:0]  baud, baud_n;
  logic [15:0] width, width_n;
  logic [2:0]  retry, retry_n;
  logic        fail_evt, hold;

  function automatic logic [2:0] classify(input logic [15:0] w);
    if (w <= 16'd650)       return 3'b100;
    else if (w <= 16'd1084) return 3'b011;
    else if (w <= 16'd1952) return 3'b010;
    else if (w <= 16'd3905) return 3'b001;
    else                    return 3'b000;
  endfunction

  // Required idle before releasing the receiver: two nominal bit periods.
  function automatic logic [15:0] settle_len(input logic [2:0] code);
    case (code)
      3'b000:  return 16'd10416;
      3'b001:  return 16'd5208;
      3'b010:  return 16'd2604;
      3'b011:  return 16'd1736;
      default: return 16'd868;
    endcase
  endfunction

  assign fall    = line_prev & ~line_s;
  assign cnt_inc = (cnt == '1) ? cnt : cnt + 16'd1;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    tcnt_n   = tcnt;
    baud_n   = baud;
    width_n  = width;
    retry_n  = retry;
    fail_evt = 1'b0;
    case (state)
      IDLE, LOCKED, FAIL: begin
        if (start) begin
          state_n = ARM;
          retry_n = '0;
        end
      end
      ARM: begin
        if (fall) begin
          state_n = MEASURE;
          cnt_n   = 16'd1;
        end
      end
      MEASURE: begin
        if (!line_s) begin
          cnt_n = cnt_inc;
          if (cnt_inc == BREAK_W) fail_evt = 1'b1;
        end else if (cnt < GLITCH_W) begin
          state_n = ARM;
        end else begin
          state_n = SETTLE;
          baud_n  = classify(cnt);
          width_n = cnt;
          cnt_n   = '0;
        end
      end
      SETTLE: begin
        if (!line_s) begin
          cnt_n = '0;
        end else begin
          cnt_n = cnt_inc;
          if (cnt_inc == settle_len(baud)) begin
            state_n = VERIFY;
            tcnt_n  = '0;
          end
        end
      end
      VERIFY: begin
        tcnt_n = tcnt + 24'd1;
        // A byte arriving on the timeout cycle still counts.
        if (rcv.rx_done) begin
          if (rcv.data_byte == SYNC_BYTE) state_n = LOCKED;
          else                            fail_evt = 1'b1;
        end else if (tcnt_n == VERIFY_TIMEOUT) begin
          fail_evt = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (fail_evt) begin
      retry_n = retry + 3'd1;
      state_n = (retry_n == 3'(MAX_RETRY)) ? FAIL : ARM;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      sync1     <= 1'b1;
      line_s    <= 1'b1;
      line_prev <= 1'b1;
      cnt       <= '0;
      tcnt      <= '0;
      baud      <= '0;
      width     <= '0;
      retry     <= '0;
      busy      <= 1'b0;
      locked    <= 1'b0;
      fail      <= 1'b0;
      hold      <= 1'b1;
    end else begin
      state     <= state_n;
      sync1     <= uart_rx;
      line_s    <= sync1;
      line_prev <= line_s;
      cnt       <= cnt_n;
      tcnt      <= tcnt_n;
      baud      <= baud_n;
      width     <= width_n;
      retry     <= retry_n;
      busy      <= (state_n == ARM) || (state_n == MEASURE) ||
                   (state_n == SETTLE) || (state_n == VERIFY);
      locked    <= (state_n == LOCKED);
      fail      <= (state_n == FAIL);
      hold      <= !((state_n == VERIFY) || (state_n == LOCKED));
    end
  end

  assign rcv.baud_set = baud;
  assign rcv.rx_hold  = hold;
  assign retry_cnt    = retry;
  assign meas_width   = width;

endmodule

// File: tb/tb_uart_autobaud_ctrl.sv
// Bench for uart_autobaud_ctrl: table of sync attempts, hand-written corner
// sequences, then random attempts scored against a rule-level model.
module tb_uart_autobaud_ctrl;
  localparam int unsigned TMO  = 1000;
  localparam int unsigned MAXR = 3;
  localparam logic [7:0]  SYNC = 8'h55;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        uart_rx = 1'b1;
  logic        busy, locked, fail;
  logic [2:0]  retry_cnt;
  logic [15:0] meas_width;
  int          n_vec = 0;
  int          n_bad = 0;

  uart_autobaud_ctrl_if bus ();

  uart_autobaud_ctrl #(
    .SYNC_BYTE      (SYNC),
    .MAX_RETRY      (MAXR),
    .VERIFY_TIMEOUT (24'(TMO))
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .uart_rx    (uart_rx),
    .rcv        (bus.master),
    .busy       (busy),
    .locked     (locked),
    .fail       (fail),
    .retry_cnt  (retry_cnt),
    .meas_width (meas_width)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          do_start;
    int unsigned w;
    logic [7:0]  vb;
    logic [2:0]  baud;
    int unsigned width;
    bit          busy, locked, fail;
    int unsigned retry;
    int unsigned fall;
  } vec_t;
  vec_t tbl [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [2:0] b, input int unsigned w,
                             input bit bz, input bit lk, input bit fl, input int unsigned r);
    check({tag, ".baud_set"},   32'(bus.baud_set), 32'(b));
    check({tag, ".meas_width"}, 32'(meas_width),   w);
    check({tag, ".busy"},       32'(busy),         32'(bz));
    check({tag, ".locked"},     32'(locked),       32'(lk));
    check({tag, ".fail"},       32'(fail),         32'(fl));
    check({tag, ".retry_cnt"},  32'(retry_cnt),    r);
    check({tag, ".rx_hold"},    32'(bus.rx_hold),  32'(!lk));
  endtask

  task automatic tick(input int unsigned n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic drive_low(input int unsigned w);
    uart_rx = 1'b0;
    tick(w);
    uart_rx = 1'b1;
  endtask

  task automatic wait_hold_fall(output int unsigned n);
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.rx_hold && n < 20000);
  endtask

  task automatic pulse_rx(input logic [7:0] b);
    bus.rx_done   = 1'b1;
    bus.data_byte = b;
    tick();
    bus.rx_done = 1'b0;
    tick(2);
  endtask

  // One sync attempt: optional start, low start bit of w clocks, idle, then the
  // receiver reports byte b once it is released.
  task automatic attempt(input bit s, input int unsigned w, input logic [7:0] b,
                         output int unsigned fall_n);
    if (s) pulse_start();
    drive_low(w);
    fall_n = 0;
    if (w < 217) tick(5);
    else begin
      wait_hold_fall(fall_n);
      pulse_rx(b);
    end
  endtask

  // Code i accepts widths from lo[i] up; anything under 217 is a glitch (7).
  function automatic logic [2:0] ref_code(input int unsigned w);
    int unsigned lo [5];
    lo = '{3906, 1953, 1085, 651, 217};
    for (int i = 0; i < 5; i++) if (w >= lo[i]) return 3'(i);
    return 3'd7;
  endfunction

  function automatic int unsigned nominal(input logic [2:0] code);
    int unsigned nom [5];
    nom = '{5208, 2604, 1302, 868, 434};
    return nom[code];
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned f, n, w;
    bit          s, m_busy, m_locked, m_fail;
    int unsigned m_retry, m_width, exp_fall;
    logic [2:0]  m_baud, code;
    logic [7:0]  b;

    tbl[0]  = '{1'b1,  434, 8'h55, 3'd4,  434, 1'b0, 1'b1, 1'b0, 0,   871};
    tbl[1]  = '{1'b1, 5208, 8'h55, 3'd0, 5208, 1'b0, 1'b1, 1'b0, 0, 10419};
    tbl[2]  = '{1'b1, 1302, 8'h55, 3'd2, 1302, 1'b0, 1'b1, 1'b0, 0,  2607};
    tbl[3]  = '{1'b1,  150, 8'h00, 3'd2, 1302, 1'b1, 1'b0, 1'b0, 0,     0};
    tbl[4]  = '{1'b0,  868, 8'h55, 3'd3,  868, 1'b0, 1'b1, 1'b0, 0,  1739};
    tbl[5]  = '{1'b1,  434, 8'hAA, 3'd4,  434, 1'b1, 1'b0, 1'b0, 1,   871};
    tbl[6]  = '{1'b0,  434, 8'hAA, 3'd4,  434, 1'b1, 1'b0, 1'b0, 2,   871};
    tbl[7]  = '{1'b0,  434, 8'hAA, 3'd4,  434, 1'b0, 1'b0, 1'b1, 3,   871};
    tbl[8]  = '{1'b1,  217, 8'h55, 3'd4,  217, 1'b0, 1'b1, 1'b0, 0,   871};
    tbl[9]  = '{1'b1,  216, 8'h00, 3'd4,  217, 1'b1, 1'b0, 1'b0, 0,     0};
    tbl[10] = '{1'b0,  650, 8'h55, 3'd4,  650, 1'b0, 1'b1, 1'b0, 0,   871};
    tbl[11] = '{1'b1,  651, 8'h55, 3'd3,  651, 1'b0, 1'b1, 1'b0, 0,  1739};
    tbl[12] = '{1'b1, 1084, 8'hA5, 3'd3, 1084, 1'b1, 1'b0, 1'b0, 1,  1739};
    tbl[13] = '{1'b0, 1085, 8'h55, 3'd2, 1085, 1'b0, 1'b1, 1'b0, 1,  2607};

    bus.rx_done   = 1'b0;
    bus.data_byte = 8'h00;

    tick(3);
    check_state("reset", 3'd0, 0, 1'b0, 1'b0, 1'b0, 0);
    reset = 1'b0;
    tick(4);
    check_state("post_reset", 3'd0, 0, 1'b0, 1'b0, 1'b0, 0);

    for (int i = 0; i < 14; i++) begin
      attempt(tbl[i].do_start, tbl[i].w, tbl[i].vb, f);
      check_state($sformatf("row%0d", i), tbl[i].baud, tbl[i].width,
                  tbl[i].busy, tbl[i].locked, tbl[i].fail, tbl[i].retry);
      if (tbl[i].fall != 0) check($sformatf("row%0d.hold_fall", i), f, tbl[i].fall);
    end

    // VERIFY timeout fires exactly TMO clocks after the receiver is released.
    pulse_start();
    drive_low(434);
    wait_hold_fall(f);
    check("tmo.hold_fall", f, 871);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.rx_hold && n < 5000);
    check("tmo.cycles", n, TMO);
    check_state("tmo", 3'd4, 434, 1'b1, 1'b0, 1'b0, 1);

    // rx_done landing on the timeout cycle must win.
    drive_low(434);
    wait_hold_fall(f);
    tick(TMO - 1);
    bus.rx_done   = 1'b1;
    bus.data_byte = SYNC;
    tick();
    bus.rx_done = 1'b0;
    tick();
    check_state("tmo_edge", 3'd4, 434, 1'b0, 1'b1, 1'b0, 1);

    pulse_rx(8'hAA);
    check_state("locked_ignore", 3'd4, 434, 1'b0, 1'b1, 1'b0, 1);

    start         = 1'b1;
    bus.rx_done   = 1'b1;
    bus.data_byte = SYNC;
    tick();
    start       = 1'b0;
    bus.rx_done = 1'b0;
    tick();
    check_state("start_wins", 3'd4, 434, 1'b1, 1'b0, 1'b0, 0);

    // Reset mid-measurement, then a fresh 19200 lock.
    uart_rx = 1'b0;
    tick(302);
    reset = 1'b1;
    #1;
    check_state("mid_reset", 3'd0, 0, 1'b0, 1'b0, 1'b0, 0);
    uart_rx = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(3);
    attempt(1'b1, 2604, SYNC, f);
    check_state("r19200", 3'd1, 2604, 1'b0, 1'b1, 1'b0, 0);
    check("r19200.hold_fall", f, 5211);

    // Line break: failure exactly when the width reaches 7812.
    pulse_start();
    uart_rx = 1'b0;
    tick(7813);
    check("break.before", 32'(retry_cnt), 0);
    tick();
    check_state("break", 3'd1, 2604, 1'b1, 1'b0, 1'b0, 1);
    tick(50);
    uart_rx = 1'b1;
    tick(5);

    // Random attempts against the rule-level model.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick(2);
    m_busy = 0; m_locked = 0; m_fail = 0; m_retry = 0; m_width = 0; m_baud = 3'd0;
    for (int i = 0; i < 8; i++) begin
      w = $urandom_range(1084, 150);
      b = ($urandom_range(1, 0) == 1) ? SYNC : 8'($urandom);
      s = !m_busy || ($urandom_range(3, 0) == 0);
      if (s && !m_busy) begin
        m_busy = 1; m_locked = 0; m_fail = 0; m_retry = 0;
      end
      code     = ref_code(w);
      exp_fall = 0;
      if (code != 3'd7) begin
        m_baud   = code;
        m_width  = w;
        exp_fall = 2 * nominal(code) + 3;
        if (b == SYNC) begin
          m_locked = 1; m_busy = 0;
        end else begin
          m_retry++;
          if (m_retry == MAXR) begin
            m_fail = 1; m_busy = 0;
          end
        end
      end
      attempt(s, w, b, f);
      check_state($sformatf("rand%0d", i), m_baud, m_width, m_busy, m_locked, m_fail, m_retry);
      if (exp_fall != 0) check($sformatf("rand%0d.hold_fall", i), f, exp_fall);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_autobaud_ctrl.md
Name: uart_autobaud_ctrl

Overview:
Automatic baud-rate configurator for the 50 MHz UART byte receiver, which takes a 3-bit baud_set and reports data_byte/rx_done.
- The host sends the sync byte 0x55 twice, with at least 2 bit-times of idle between the two frames.
- The controller measures the start-bit width of the first frame, classifies it into one of five baud codes, and drives baud_set.
- It holds the receiver in reset until the code is settled, then confirms the code by checking the second frame through the receiver.
- It reports locked or fail, retrying up to MAX_RETRY times.

Parameters:
SYNC_BYTE, 8'h55, expected verification byte.
MAX_RETRY, 3, failed attempts before FAIL (1..7).
VERIFY_TIMEOUT, 24'd10_000_000, clocks to wait for rx_done in VERIFY (200 ms).

Ports:
clk  in  1  system clock, 50 MHz
reset  in  1  asynchronous, active-high
start  in  1  single-cycle pulse: begin detection
uart_rx  in  1  raw serial line, asynchronous to clk
rx_done  in  1  receiver byte-complete pulse
data_byte  in  8  receiver byte, valid with rx_done
baud_set  out  3  baud code to receiver (000=9600, 001=19200, 010=38400, 011=57600, 100=115200)
rx_hold  out  1  active-high hold/reset request to receiver
busy  out  1  high in ARM, MEASURE, SETTLE, VERIFY
locked  out  1  high in LOCKED
fail  out  1  high in FAIL
retry_cnt  out  3  failed attempts in the current run
meas_width  out  16  last classified start-bit width, in clocks

Behaviour:
- Reset values:
  - baud_set=000, rx_hold=1, busy=0, locked=0, fail=0, retry_cnt=0, meas_width=0, state=IDLE.
  - Synchroniser flops reset to 1 (line idle); no false edge out of reset.
- Line conditioning:
  - uart_rx passes through a 2-FF synchroniser to give line_s.
  - A falling edge is line_s=0 with the previous line_s=1.
- States:
  - IDLE, LOCKED, FAIL: start -> ARM. Clears retry_cnt, locked and fail; sets rx_hold=1.
  - ARM: a falling edge -> MEASURE, with width counter = 1.
  - MEASURE:
    - Counter +1 per cycle while line_s=0, saturating at 16'hFFFF.
    - Counter reaching 7812 (1.5 bit at 9600) -> line break. Counts as a failure, then retry logic applies.
    - line_s returns to 1 with width W -> classify in that cycle. baud_set and meas_width are registered the next cycle.
  - Classification of W:
    - W<217: glitch -> ARM; no retry increment; baud_set unchanged.
    - 217..650 -> 100.
    - 651..1084 -> 011.
    - 1085..1952 -> 010.
    - 1953..3905 -> 001.
    - 3906..7811 -> 000.
  - SETTLE:
    - Idle counter runs while line_s=1 and clears on any line_s=0.
    - Reaching 2 x nominal period -> VERIFY and rx_hold=0.
    - Nominal period per code: 5208, 2604, 1302, 868, 434 clocks.
  - VERIFY:
    - Timeout counter starts at 0.
    - rx_done with data_byte==SYNC_BYTE -> LOCKED.
    - rx_done with a mismatch, or the counter reaching VERIFY_TIMEOUT -> failure.
  - Failure handling:
    - retry_cnt += 1 and rx_hold=1.
    - New retry_cnt == MAX_RETRY -> FAIL; otherwise -> ARM.
  - LOCKED: rx_hold=0 and baud_set frozen; further rx_done is ignored.
- start in ARM, MEASURE, SETTLE or VERIFY is ignored.
- baud_set changes only while rx_hold=1.
- busy, locked and fail are registered decodes of the state and are mutually exclusive.
- Simultaneous events:
  - rx_done and timeout in the same cycle: rx_done wins.
  - start and rx_done in the same cycle in LOCKED: start wins.
- Reset mid-operation: all state returns to reset values immediately; baud_set returns to 000.

Test Plan:
1. start; 0x55 at 115200 (434 clk/bit), 10-bit idle, 0x55 -> meas_width ~434, baud_set=100, rx_hold falls after 868 idle clocks, locked=1, retry_cnt=0.
2. Same sequence at 9600 (5208 clk/bit) -> baud_set=000, locked=1; repeat at 38400 -> baud_set=010.
3. start; 150-clock low glitch, then a valid 57600 sequence -> glitch ignored, retry_cnt=0, baud_set=011, locked=1.
4. start; 115200 measure frame, then 0xAA three times -> retry_cnt 1, 2, 3; fail=1, busy=0, rx_hold=1.
5. start; valid measure frame, no second frame -> VERIFY timeout after 10_000_000 clocks, retry_cnt=1, state ARM.
6. Assert reset during MEASURE at width 300 -> all outputs at reset values next cycle; start plus a valid 19200 sequence -> baud_set=001, locked=1.
